// File: rtl/game_ctrl.sv
// Memory-sequence game controller: shows a growing tile sequence, then checks the player's replay.
// Optional input-wait timeout is compiled in with GAME_CTRL_TIMEOUT_EN.
module game_ctrl #(
  parameter int unsigned SHOW_CYCLES    = 25000000,
  parameter int unsigned GAP_CYCLES     = 12500000,
  parameter int unsigned TIMEOUT_CYCLES = 250000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        any_key,
  input  logic        player_input,
  input  logic        check,
  output logic [17:0] seq,
  output logic [3:0]  seq_counter,
  output logic        playerEN,
  output logic        checkEN,
  output logic        show_valid,
  output logic [1:0]  show_tile,
  output logic [3:0]  round,
  output logic        win,
  output logic        lose
);

  localparam logic [3:0] S_IDLE     = 4'd0;
  localparam logic [3:0] S_GEN      = 4'd1;
  localparam logic [3:0] S_SHOW_ON  = 4'd2;
  localparam logic [3:0] S_SHOW_OFF = 4'd3;
  localparam logic [3:0] S_RELEASE  = 4'd4;
  localparam logic [3:0] S_WAIT_IN  = 4'd5;
  localparam logic [3:0] S_CHECK    = 4'd6;
  localparam logic [3:0] S_EVAL     = 4'd7;
  localparam logic [3:0] S_WIN      = 4'd8;
  localparam logic [3:0] S_LOSE     = 4'd9;

  logic [3:0]  state;
  logic [17:0] lfsr;
  logic [31:0] tmr;
  logic        more_tiles;
  logic [4:0]  tile_idx;
  logic [4:0]  tile_idx1;

`ifdef GAME_CTRL_TIMEOUT_EN
  logic [31:0] to_cnt;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT_CYCLES;
`endif

  // Another tile remains in the current round while the index is below round-1.
  assign more_tiles = (seq_counter < (round - 4'd1));

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      lfsr        <= 18'h00001;
      seq         <= '0;
      seq_counter <= '0;
      round       <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      tmr         <= '0;
`ifdef GAME_CTRL_TIMEOUT_EN
      to_cnt      <= '0;
`endif
    end else begin
      // x^18 + x^11 + 1, free-running in every state
      lfsr <= {lfsr[16:0], lfsr[17] ^ lfsr[10]};
      case (state)
        S_IDLE, S_WIN, S_LOSE: begin
          if (start) state <= S_GEN;
        end
        S_GEN: begin
          seq         <= lfsr;
          round       <= 4'd1;
          seq_counter <= '0;
          win         <= 1'b0;
          lose        <= 1'b0;
          tmr         <= '0;
          state       <= S_SHOW_ON;
        end
        S_SHOW_ON: begin
          if (tmr == SHOW_CYCLES - 1) begin
            tmr   <= '0;
            state <= S_SHOW_OFF;
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_SHOW_OFF: begin
          if (tmr == GAP_CYCLES - 1) begin
            tmr <= '0;
            if (more_tiles) begin
              seq_counter <= seq_counter + 4'd1;
              state       <= S_SHOW_ON;
            end else begin
              seq_counter <= '0;
              state       <= S_RELEASE;
            end
          end else begin
            tmr <= tmr + 32'd1;
          end
        end
        S_RELEASE: begin
          // Wait for every key to be up so one press is never counted twice.
          if (!any_key) begin
            state <= S_WAIT_IN;
`ifdef GAME_CTRL_TIMEOUT_EN
            to_cnt <= '0;
`endif
          end
        end
        S_WAIT_IN: begin
          if (player_input) begin
            state <= S_CHECK;
`ifdef GAME_CTRL_TIMEOUT_EN
          end else if (to_cnt == TIMEOUT_CYCLES - 1) begin
            lose  <= 1'b1;
            state <= S_LOSE;
          end else begin
            to_cnt <= to_cnt + 32'd1;
`endif
          end
        end
        S_CHECK: begin
          state <= S_EVAL;
        end
        S_EVAL: begin
          if (!check) begin
            lose  <= 1'b1;
            state <= S_LOSE;
          end else if (more_tiles) begin
            seq_counter <= seq_counter + 4'd1;
            state       <= S_RELEASE;
          end else if (round == 4'd9) begin
            win   <= 1'b1;
            state <= S_WIN;
          end else begin
            round       <= round + 4'd1;
            seq_counter <= '0;
            tmr         <= '0;
            state       <= S_SHOW_ON;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Tile k is stored with its high bit at seq[2k] and low bit at seq[2k+1].
  assign tile_idx  = {seq_counter, 1'b0};
  assign tile_idx1 = tile_idx | 5'd1;

  always_comb begin
    show_valid = (state == S_SHOW_ON);
    playerEN   = (state == S_WAIT_IN);
    checkEN    = (state == S_CHECK);
    show_tile  = 2'b00;
    if (show_valid) show_tile = {seq[tile_idx], seq[tile_idx1]};
  end

endmodule

// File: tb/tb_game_ctrl.sv
// Scoreboard bench for game_ctrl: stimulus pushes expected show/check/win/lose events,
// a negedge monitor reconstructs the same events from the DUT outputs and compares.
module tb_game_ctrl;
  localparam int SC = 4;
  localparam int GC = 2;
  localparam int TC = 10;

  localparam int K_SHOW = 1;
  localparam int K_CHK  = 2;
  localparam int K_WIN  = 3;
  localparam int K_LOSE = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        any_key = 1'b0;
  logic        player_input = 1'b0;
  logic        check = 1'b0;
  logic [17:0] seq;
  logic [3:0]  seq_counter;
  logic        playerEN;
  logic        checkEN;
  logic        show_valid;
  logic [1:0]  show_tile;
  logic [3:0]  round;
  logic        win;
  logic        lose;

  game_ctrl #(.SHOW_CYCLES(SC), .GAP_CYCLES(GC), .TIMEOUT_CYCLES(TC)) dut (
    .clk(clk), .reset(reset), .start(start), .any_key(any_key),
    .player_input(player_input), .check(check), .seq(seq),
    .seq_counter(seq_counter), .playerEN(playerEN), .checkEN(checkEN),
    .show_valid(show_valid), .show_tile(show_tile), .round(round),
    .win(win), .lose(lose)
  );

  always #5 clk = ~clk;

  typedef struct {int kind; int a; int b;} ev_t;
  ev_t exp_q[$];
  int tests = 0;
  int fails = 0;

  // Reference LFSR, x^18 + x^11 + 1, seeded with 1 on reset.
  logic [17:0] m_lfsr;
  always @(posedge clk)
    if (reset) m_lfsr <= 18'h00001;
    else       m_lfsr <= {m_lfsr[16:0], m_lfsr[17] ^ m_lfsr[10]};

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input int kind, input int a, input int b);
    exp_q.push_back('{kind, a, b});
  endtask

  task automatic emit(input int kind, input int a, input int b);
    ev_t e;
    if (exp_q.size() == 0) begin
      tests++;
      fails++;
      $display("FAIL unexpected_event: got kind %0d a 0x%0h b 0x%0h, expected no event", kind, a, b);
    end else begin
      e = exp_q.pop_front();
      chk($sformatf("event_kind%0d", e.kind), kind * 65536 + a * 256 + b,
          e.kind * 65536 + e.a * 256 + e.b);
    end
  endtask

  function automatic int tile(input logic [17:0] l, input int k);
    logic [1:0] t;
    t = {l[2*k], l[2*k+1]};
    return int'(t);
  endfunction

  function automatic logic sel_sig(input int s);
    case (s)
      0:       return playerEN;
      1:       return show_valid;
      2:       return win;
      default: return lose;
    endcase
  endfunction

  task automatic wait_sig(input int s, input string nm);
    int n = 0;
    while (sel_sig(s) !== 1'b1 && n < 600) begin
      @(negedge clk);
      n++;
    end
    if (sel_sig(s) !== 1'b1) begin
      tests++;
      fails++;
      $display("FAIL wait_%s: still low after %0d cycles, expected high", nm, n);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_seq"}, seq, 0);
    chk({tag, "_seq_counter"}, seq_counter, 0);
    chk({tag, "_round"}, round, 0);
    chk({tag, "_playerEN"}, playerEN, 0);
    chk({tag, "_checkEN"}, checkEN, 0);
    chk({tag, "_show_valid"}, show_valid, 0);
    chk({tag, "_show_tile"}, show_tile, 0);
    chk({tag, "_win"}, win, 0);
    chk({tag, "_lose"}, lose, 0);
  endtask

  // Called at a negedge with the DUT in IDLE/WIN/LOSE; returns at the first SHOW_ON sample.
  task automatic start_game(input bit exp_show, output logic [17:0] l);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    l = m_lfsr;
    if (exp_show) push(K_SHOW, tile(l, 0), SC);
    @(negedge clk);
    chk("gen_seq", seq, l);
    chk("gen_round", round, 1);
    chk("gen_counter", seq_counter, 0);
    chk("gen_win", win, 0);
    chk("gen_lose", lose, 0);
  endtask

  task automatic play(input bit ok, input int r, input int k, input logic [17:0] l, input bit key);
    wait_sig(0, "playerEN");
    push(K_CHK, r * 16 + k, 2);
    if (!ok) push(K_LOSE, r, k);
    else if (k == r - 1) begin
      if (r == 9) push(K_WIN, 9, 8);
      else for (int j = 0; j <= r; j++) push(K_SHOW, tile(l, j), SC);
    end
    check = ok;
    player_input = 1'b1;
    if (key) any_key = 1'b1;
    @(negedge clk);
    player_input = 1'b0;
  endtask

  // Monitor: turns output activity into events and pops the scoreboard.
  initial begin : monitor
    int sv_run, sv_tile, ck_run, ck_pos, ck_pe;
    bit sv_bad;
    logic win_q, lose_q;
    sv_run = 0; sv_tile = 0; sv_bad = 0; ck_run = 0; ck_pos = 0; ck_pe = 0;
    win_q = 1'b0; lose_q = 1'b0;
    forever begin
      @(negedge clk);
      if (reset) begin
        sv_run = 0; sv_bad = 0; ck_run = 0; ck_pe = 0;
        win_q = 1'b0; lose_q = 1'b0;
      end else begin
        if (show_valid) begin
          if (sv_run == 0) sv_tile = int'(show_tile);
          else if (int'(show_tile) != sv_tile) sv_bad = 1;
          sv_run++;
        end else if (sv_run != 0) begin
          emit(K_SHOW, sv_bad ? 15 : sv_tile, sv_run);
          sv_run = 0;
          sv_bad = 0;
        end
        if (checkEN) begin
          if (ck_run == 0) ck_pos = int'({round, seq_counter});
          if (playerEN) ck_pe = 1;
          ck_run++;
        end else if (ck_run != 0) begin
          emit(K_CHK, ck_pos, ck_run * 2 + ck_pe);
          ck_run = 0;
          ck_pe = 0;
        end
        if (win === 1'b1 && win_q !== 1'b1) emit(K_WIN, int'(round), int'(seq_counter));
        if (lose === 1'b1 && lose_q !== 1'b1) emit(K_LOSE, int'(round), int'(seq_counter));
        win_q = win;
        lose_q = lose;
      end
    end
  end

  initial begin
    logic [17:0] l1, l2, l3;
    int cnt;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    check_reset("por");
    reset = 1'b0;

    // Game 1: three rounds, wrong tile at round 3 index 1.
    start_game(1, l1);
    cnt = 0;
    for (int i = 0; i < 40 && playerEN !== 1'b1; i++) begin
      if (show_valid === 1'b0) cnt++;
      @(negedge clk);
    end
    chk("gap_plus_release_cycles", cnt, GC + 1);
    for (int r = 1; r <= 3; r++) begin
      for (int k = 0; k < r; k++) begin
        if (r == 3 && k == 1) begin
          play(0, r, k, l1, 0);
          break;
        end
        play(1, r, k, l1, 0);
      end
    end
    wait_sig(3, "lose");
    cnt = 0;
    for (int i = 0; i < 50; i++) begin
      if (lose === 1'b1 && playerEN === 1'b0 && show_valid === 1'b0 && checkEN === 1'b0) cnt++;
      @(negedge clk);
    end
    chk("lose_hold_cycles", cnt, 50);

    // Game 2: full win, with keys held after the first input of round 2.
    start_game(1, l2);
    chk("new_seq_differs", seq != l1, 1);
    for (int r = 1; r <= 9; r++) begin
      for (int k = 0; k < r; k++) begin
        play(1, r, k, l2, r == 2 && k == 0);
        if (r == 2 && k == 0) begin
          cnt = 0;
          repeat (20) begin
            @(negedge clk);
            if (playerEN !== 1'b0) cnt++;
          end
          chk("key_held_playerEN_high_cycles", cnt, 0);
          any_key = 1'b0;
          @(negedge clk);
          chk("key_release_playerEN", playerEN, 1);
        end
      end
    end
    wait_sig(2, "win");
    chk("win_flag", win, 1);
    chk("win_round", round, 9);
    chk("win_playerEN", playerEN, 0);

    // Game 3: reset in the middle of the first show.
    start_game(0, l3);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_reset("mid_show");
    @(negedge clk);
    reset = 1'b0;

    // Game 4: player never answers.
    start_game(1, l3);
    wait_sig(0, "playerEN");
`ifdef GAME_CTRL_TIMEOUT_EN
    push(K_LOSE, 1, 0);
    repeat (TC) @(negedge clk);
    chk("timeout_lose", lose, 1);
    chk("timeout_playerEN", playerEN, 0);
`else
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (playerEN === 1'b1) cnt++;
    end
    chk("no_timeout_wait_cycles", cnt, 1000);
`endif

    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/game_ctrl.md
GAME_CTRL -- requirements
Module: game_ctrl

Interface
REQ-001 SHALL have parameter SHOW_CYCLES, default 25000000, meaning the number of cycles each tile is shown.
REQ-002 SHALL have parameter GAP_CYCLES, default 12500000, meaning the number of blank cycles after each shown tile.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 250000000, meaning the input wait limit; it is used only under the REQ-026 macro.
REQ-004 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 Port start, input, 1 bit: single-cycle request to begin a new game.
REQ-007 Port any_key, input, 1 bit: OR of the q/w/a/s key levels.
REQ-008 Port player_input, input, 1 bit: the downstream player stage has registered a tile.
REQ-009 Port check, input, 1 bit: result from the player stage, valid the cycle after checkEN.
REQ-010 Port seq, output, 18 bits: nine 2-bit tiles; tile k has bit1 at seq[2k] and bit0 at seq[2k+1].
REQ-011 Port seq_counter, output, 4 bits: index of the current tile, range 0..8.
REQ-012 Port playerEN and port checkEN, outputs, 1 bit each: enables to the player stage.
REQ-013 Port show_valid (output, 1 bit) and port show_tile (output, 2 bits): display drive.
REQ-014 Port round (output, 4 bits, range 1..9), port win (output, 1 bit) and port lose (output, 1 bit).

Function
REQ-015 SHALL run an 18-bit Fibonacci LFSR, polynomial x^18+x^11+1, advancing every cycle in all states; it is never zero.
REQ-016 States SHALL be IDLE, GEN, SHOW_ON, SHOW_OFF, RELEASE, WAIT_IN, CHECK, EVAL, WIN, LOSE.
REQ-017 IDLE/WIN/LOSE: on start go to GEN. start is ignored in every other state.
REQ-018 GEN (one cycle): load seq with the current LFSR value; round=1; seq_counter=0; win=lose=0; go to SHOW_ON.
REQ-019 SHOW_ON: show_valid=1 and show_tile={seq[2*seq_counter],seq[2*seq_counter+1]} for exactly SHOW_CYCLES cycles; then go to SHOW_OFF.
REQ-020 SHOW_OFF: show_valid=0 for GAP_CYCLES cycles. If seq_counter<round-1: seq_counter++ and go to SHOW_ON. Otherwise: seq_counter=0 and go to RELEASE.
REQ-021 RELEASE: playerEN=0. Go to WAIT_IN on the first cycle with any_key==0; stay while any_key==1.
REQ-022 WAIT_IN: playerEN=1. On player_input==1 go to CHECK.
REQ-023 CHECK (one cycle): playerEN=0, checkEN=1; go to EVAL. checkEN is high only in CHECK.
REQ-024 EVAL: sample check.
- check==0: go to LOSE.
- Else if seq_counter<round-1: seq_counter++, go to RELEASE.
- Else if round==9: go to WIN.
- Else: round++, seq_counter=0, go to SHOW_ON.
REQ-025 WIN sets win=1 and LOSE sets lose=1; both are held, with playerEN=checkEN=show_valid=0, until the next GEN.

Configuration
REQ-026 With GAME_CTRL_TIMEOUT_EN defined: a counter clears on entry to WAIT_IN; if TIMEOUT_CYCLES cycles elapse without player_input, go to LOSE. Without the macro: WAIT_IN waits indefinitely and no timeout counter exists.

Reset
REQ-027 On reset, from any state including mid-show or mid-check, the next state SHALL be IDLE.
REQ-028 Reset values: seq=0, seq_counter=0, round=0, playerEN=checkEN=show_valid=0, show_tile=0, win=lose=0, LFSR=18'h00001, all timers 0.

Verification (SHOW_CYCLES=4, GAP_CYCLES=2, TIMEOUT_CYCLES=10)
REQ-029 Reset then start at LFSR=L -> seq==L one cycle later; show_valid high for exactly 4 cycles with show_tile={L[0],L[1]}; then low for 2 cycles; then RELEASE.
REQ-030 Player model returns correct tiles for rounds 1-2 -> round goes 1->2->3; checkEN is a 1-cycle pulse per input; seq_counter steps 0..round-1.
REQ-031 Wrong tile (check=0) at round 3, index 1 -> lose=1, playerEN=0, held for 50 cycles; then start -> GEN with a new seq and lose=0.
REQ-032 Correct play through all 9 rounds -> win=1 after the EVAL of round 9, index 8; round==9.
REQ-033 any_key held high for 20 cycles after an input -> playerEN stays 0 throughout; it rises 1 cycle after any_key falls.
REQ-034 Reset asserted during SHOW_ON -> the next cycle shows all REQ-028 values. Timeout scenario, macro on: no input for 10 cycles -> lose=1; macro off: still in WAIT_IN after 1000 cycles.
